// File: rtl/instr_fetch_unit_pkg.sv
// Shared core definitions for the fetch stage and the IR/decode logic:
// fetch FSM state encoding, PC stepping, reset PC default and the
// instruction field positions.
package instr_fetch_unit_pkg;

   // Fetch FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } fetch_state_e;

   // Sequential instruction stride in bytes
   localparam logic [31:0] PC_STEP          = 32'd4;

   // Default PC value after reset (word aligned)
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Instruction field positions. Register/immediate/jump fields overlap
   // because the formats share bit ranges; decode picks by opcode.
   localparam int OPC_MSB  = 31;
   localparam int OPC_LSB  = 26;
   localparam int RS1_MSB  = 25;
   localparam int RS1_LSB  = 22;
   localparam int RS2_MSB  = 21;
   localparam int RS2_LSB  = 18;
   localparam int RD_MSB   = 17;
   localparam int RD_LSB   = 14;
   localparam int IMM_MSB  = 15;
   localparam int IMM_LSB  = 0;
   localparam int JOFF_MSB = 25;
   localparam int JOFF_LSB = 0;
   localparam int MODE_MSB = 1;
   localparam int MODE_LSB = 0;

   // Force a byte address onto a word boundary
   function automatic logic [31:0] align_pc(input logic [31:0] addr);
      return addr & ~32'd3;
   endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, runs a req/ack read against instruction
// memory and presents one instruction word per fetch to the IR.
// Handshake: imem_req rises in the first REQ cycle and, together with
// imem_addr, is held stable until the cycle in which imem_ack is sampled
// high (transfer completes at that edge) or until the wait bound expires.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int unsigned TIMEOUT  = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_start,
   input  logic        pc_load,
   input  logic [31:0] pc_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   output logic [31:0] pc,
   output logic        busy,
   output logic        fetch_err
);

   // Wait counter wide enough for TIMEOUT-1; one bit when the bound is off
   localparam int unsigned      CNT_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

   fetch_state_e     state_q,      state_d;
   logic [31:0]      pc_q,         pc_d;
   logic [31:0]      inst_q,       inst_d;
   logic [31:0]      inst_pc_q,    inst_pc_d;
   logic [CNT_W-1:0] cnt_q,        cnt_d;
   logic             imem_req_q,   imem_req_d;
   logic             inst_valid_q, inst_valid_d;
   logic             fetch_err_q,  fetch_err_d;
   logic             busy_q,       busy_d;
   logic             timeout_hit;

   // Next-state, datapath and registered-output computation
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      inst_d      = inst_q;
      inst_pc_d   = inst_pc_q;
      cnt_d       = cnt_q;
      fetch_err_d = 1'b0;
      timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

      case (state_q)
         ST_IDLE: begin
            // A load in the same cycle as a start redirects this fetch
            if (pc_load) begin
               pc_d = align_pc(pc_target);
            end
            if (fetch_start) begin
               state_d = ST_REQ;
               cnt_d   = '0;
            end
         end
         ST_REQ: begin
            // Ack beats a simultaneous timeout
            if (imem_ack) begin
               inst_d    = imem_rdata;
               inst_pc_d = pc_q;
               pc_d      = pc_q + PC_STEP;
               state_d   = ST_DONE;
            end else if (timeout_hit) begin
               fetch_err_d = 1'b1;
               cnt_d       = '0;
               state_d     = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      imem_req_d   = (state_d == ST_REQ);
      inst_valid_d = (state_d == ST_DONE);
      busy_d       = (state_d != ST_IDLE);
   end

   // FSM state, datapath and output registers; reset clears imem_req at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         pc_q         <= RESET_PC;
         inst_q       <= '0;
         inst_pc_q    <= '0;
         cnt_q        <= '0;
         imem_req_q   <= 1'b0;
         inst_valid_q <= 1'b0;
         fetch_err_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         cnt_q        <= cnt_d;
         imem_req_q   <= imem_req_d;
         inst_valid_q <= inst_valid_d;
         fetch_err_q  <= fetch_err_d;
         busy_q       <= busy_d;
      end
   end

   assign imem_req   = imem_req_q;
   assign imem_addr  = pc_q;
   assign pc         = pc_q;
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;
   assign inst_valid = inst_valid_q;
   assign fetch_err  = fetch_err_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed and randomized fetches checked
// against a transaction-level model of the fetch stage.
module tb_instr_fetch_unit;

   localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
   localparam int          TB_TIMEOUT  = 15;

   logic        clk;
   logic        rst_n;
   logic        fetch_start;
   logic        pc_load;
   logic [31:0] pc_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic [31:0] pc;
   logic        busy;
   logic        fetch_err;

   int n_checks;
   int n_errors;

   // Reference model state
   logic [31:0] model_pc;
   logic [31:0] model_inst;
   logic [31:0] model_inst_pc;
   logic [31:0] exp_q[$];

   instr_fetch_unit #(
      .RESET_PC (TB_RESET_PC),
      .TIMEOUT  (TB_TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fetch_start(fetch_start),
      .pc_load    (pc_load),
      .pc_target  (pc_target),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .inst       (inst),
      .inst_pc    (inst_pc),
      .inst_valid (inst_valid),
      .pc         (pc),
      .busy       (busy),
      .fetch_err  (fetch_err)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete fetch with `waits` wait cycles before the ack.
   // Entered and left #1 after a rising edge with the unit idle.
   task automatic fetch(input int waits, input logic [31:0] rdata,
                        input bit do_load, input logic [31:0] target, input bit noise);
      logic [31:0] req_addr;
      if (do_load) begin
         pc_load   = 1'b1;
         pc_target = target;
         model_pc  = target & 32'hFFFF_FFFC;
      end
      fetch_start = 1'b1;
      req_addr    = model_pc;
      step();
      fetch_start = 1'b0;
      pc_load     = 1'b0;
      pc_target   = $urandom;
      for (int k = 0; k <= waits; k++) begin
         chk("req_high", imem_req, 1);
         chk("req_addr", imem_addr, req_addr);
         chk("busy_req", busy, 1);
         chk("valid_low_req", inst_valid, 0);
         if (k == waits) begin
            imem_ack   = 1'b1;
            imem_rdata = rdata;
         end else if (noise) begin
            fetch_start = 1'b1;
            pc_load     = 1'b1;
            pc_target   = $urandom;
            imem_rdata  = $urandom;
         end
         step();
         imem_ack    = 1'b0;
         fetch_start = 1'b0;
         pc_load     = 1'b0;
         imem_rdata  = $urandom;
      end
      exp_q.push_back(rdata);
      model_inst    = rdata;
      model_inst_pc = req_addr;
      model_pc      = req_addr + 32'd4;
      chk("valid_pulse", inst_valid, 1);
      chk("inst", inst, exp_q.pop_front());
      chk("inst_pc", inst_pc, model_inst_pc);
      chk("pc_after", pc, model_pc);
      chk("req_low_done", imem_req, 0);
      chk("err_low_done", fetch_err, 0);
      step();
      chk("valid_one_cycle", inst_valid, 0);
      chk("idle_after", busy, 0);
      chk("pc_hold", pc, model_pc);
      chk("inst_hold", inst, model_inst);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      model_pc      = TB_RESET_PC;
      model_inst    = '0;
      model_inst_pc = '0;
      exp_q.delete();
   endtask

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      rst_n       = 1'b0;
      fetch_start = 1'b0;
      pc_load     = 1'b0;
      pc_target   = '0;
      imem_ack    = 1'b0;
      imem_rdata  = '0;

      // Reset values
      step();
      step();
      chk("rst_pc", pc, TB_RESET_PC);
      chk("rst_addr", imem_addr, TB_RESET_PC);
      chk("rst_inst", inst, 0);
      chk("rst_inst_pc", inst_pc, 0);
      chk("rst_req", imem_req, 0);
      chk("rst_valid", inst_valid, 0);
      chk("rst_err", fetch_err, 0);
      chk("rst_busy", busy, 0);
      rst_n         = 1'b1;
      model_pc      = TB_RESET_PC;
      model_inst    = '0;
      model_inst_pc = '0;
      step();

      // Zero-wait fetch
      fetch(0, 32'h09A0_4033, 1'b0, 32'h0, 1'b0);
      chk("t1_inst", inst, 32'h09A0_4033);
      chk("t1_inst_pc", inst_pc, 32'h0);
      chk("t1_pc", pc, 32'h4);

      // Three back-to-back fetches with 3 wait cycles
      apply_reset();
      for (int i = 0; i < 3; i++) fetch(3, $urandom, 1'b0, 32'h0, 1'b0);
      chk("t2_pc", pc, 32'd12);

      // Load and start together
      fetch(2, $urandom, 1'b1, 32'h0000_0103, 1'b0);
      chk("t3_inst_pc", inst_pc, 32'h100);
      chk("t3_pc", pc, 32'h104);

      // Timeout with no ack
      fetch_start = 1'b1;
      step();
      fetch_start = 1'b0;
      for (int k = 0; k < TB_TIMEOUT; k++) begin
         chk("to_req_high", imem_req, 1);
         chk("to_err_low", fetch_err, 0);
         step();
      end
      chk("to_req_dropped", imem_req, 0);
      chk("to_err_pulse", fetch_err, 1);
      chk("to_idle", busy, 0);
      chk("to_pc", pc, model_pc);
      chk("to_inst", inst, model_inst);
      chk("to_no_valid", inst_valid, 0);
      step();
      chk("to_err_one_cycle", fetch_err, 0);

      // Ack in the last allowed cycle wins over the timeout
      fetch(TB_TIMEOUT - 1, $urandom, 1'b0, 32'h0, 1'b0);
      chk("late_ack_no_err", fetch_err, 0);

      // Wrap-around with ignored inputs during REQ
      fetch(4, $urandom, 1'b1, 32'hFFFF_FFFC, 1'b1);
      chk("wrap_pc", pc, 32'h0);
      chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);

      // Ack outside REQ is ignored
      imem_ack   = 1'b1;
      imem_rdata = ~model_inst;
      step();
      imem_ack = 1'b0;
      chk("idle_ack_inst", inst, model_inst);
      chk("idle_ack_valid", inst_valid, 0);
      chk("idle_ack_busy", busy, 0);

      // Randomized fetches
      for (int i = 0; i < 24; i++) begin
         fetch($urandom_range(0, TB_TIMEOUT - 1), $urandom,
               ($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 1) == 1));
         for (int g = $urandom_range(0, 2); g > 0; g--) begin
            step();
            chk("gap_pc", pc, model_pc);
            chk("gap_busy", busy, 0);
         end
      end

      // Reset mid-fetch followed by a late ack
      fetch_start = 1'b1;
      step();
      fetch_start = 1'b0;
      step();
      chk("mr_req_high", imem_req, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_req_async", imem_req, 0);
      chk("mr_busy", busy, 0);
      chk("mr_pc", pc, TB_RESET_PC);
      chk("mr_inst", inst, 0);
      model_pc      = TB_RESET_PC;
      model_inst    = '0;
      model_inst_pc = '0;
      exp_q.delete();
      step();
      rst_n      = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = $urandom;
      step();
      imem_ack = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("mr_no_valid", inst_valid, 0);
         chk("mr_no_err", fetch_err, 0);
         chk("mr_no_req", imem_req, 0);
         chk("mr_pc_hold", pc, model_pc);
         chk("mr_inst_hold", inst, model_inst);
         step();
      end

      // Normal fetch after reset recovery
      fetch(1, $urandom, 1'b0, 32'h0, 1'b0);
      chk("post_rst_pc", pc, TB_RESET_PC + 32'd4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
